// File: rtl/md_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Holds the funct3 op codes, FSM states and the divide special-case constants.
package md_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // rs1 is treated as signed by the high-multiply, signed divide and signed remainder ops
  function automatic logic op_signed_a(md_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // MULHSU treats rs2 as unsigned
  function automatic logic op_signed_b(md_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/md_cond_neg.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fixup.
module md_cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide sharing {hi,lo}.
// Build option MD_FAST_MUL_EN: multiplies use a single-cycle 33x33 signed multiplier and skip RUN.
//
// state | meaning
// IDLE  | waiting for MDStart; special cases resolve straight to DONE
// RUN   | one shift-add / restoring-divide iteration per cycle, 32 cycles
// DONE  | MDDone pulse, MDResult valid; always returns to IDLE
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            MDStart,
  input  logic [2:0]      MDOp,
  input  logic [XLEN-1:0] MDA,
  input  logic [XLEN-1:0] MDB,
  output logic            MDBusy,
  output logic            MDDone,
  output logic [XLEN-1:0] MDResult
);
  import md_pkg::*;

  md_state_t        state, state_nx;
  md_op_t           op_in, op_q;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  hi, lo, opb;
  logic [XLEN-1:0]  hi_nx, lo_nx;
  logic             res_neg;
  logic [XLEN-1:0]  result_q;

  logic             a_neg, b_neg, start_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             div0, ovf, special;
  logic [XLEN-1:0]  special_val;
  logic             fast_hit;
  logic [XLEN-1:0]  fast_val;
  logic             last;

  assign op_in = md_op_t'(MDOp);
  assign a_neg = op_signed_a(op_in) & MDA[XLEN-1];
  assign b_neg = op_signed_b(op_in) & MDB[XLEN-1];

  md_cond_neg #(.W(XLEN)) u_abs_a (.val(MDA), .neg(a_neg), .res(a_mag));
  md_cond_neg #(.W(XLEN)) u_abs_b (.val(MDB), .neg(b_neg), .res(b_mag));

  // remainder follows the dividend's sign; everything else follows the sign of the product/quotient
  assign start_neg = (op_in[2] & op_in[1]) ? a_neg : (a_neg ^ b_neg);

  assign div0    = op_in[2] & (MDB == '0);
  assign ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) && (MDA == INT_MIN) && (MDB == '1);
  assign special = div0 | ovf;

  always_comb begin
    special_val = '0;
    if (div0)
      special_val = op_in[1] ? MDA : DIV0_Q;
    else if (ovf)
      special_val = op_in[1] ? '0 : INT_MIN;
  end

`ifdef MD_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN+1:0] fprod;

  assign fa       = {op_signed_a(op_in) & MDA[XLEN-1], MDA};
  assign fb       = {op_signed_b(op_in) & MDB[XLEN-1], MDB};
  assign fprod    = fa * fb;
  assign fast_hit = ~op_in[2];
  assign fast_val = (op_in == OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign fast_hit = 1'b0;
  assign fast_val = '0;
`endif

  // one iteration of either algorithm; 33-bit add/sub keeps the carry/borrow
  logic [XLEN:0] add_sum, rem_sh, sub_diff;

  assign add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
  assign rem_sh   = {hi, lo[XLEN-1]};
  assign sub_diff = rem_sh - {1'b0, opb};

  always_comb begin
    hi_nx = hi;
    lo_nx = lo;
    if (op_q[2]) begin
      if (!sub_diff[XLEN]) begin
        hi_nx = sub_diff[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = rem_sh[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = add_sum[XLEN:1];
      lo_nx = {add_sum[0], lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_fix, run_val;

  md_cond_neg #(.W(2*XLEN)) u_fix_prod (.val({hi_nx, lo_nx}), .neg(res_neg), .res(prod_fix));
  md_cond_neg #(.W(XLEN))   u_fix_div  (.val(op_q[1] ? hi_nx : lo_nx), .neg(res_neg), .res(div_fix));

  assign run_val = op_q[2] ? div_fix :
                   (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

  assign last = (cnt == CNT_W'(XLEN-1));

  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (MDStart) state_nx = (special | fast_hit) ? DONE : RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    MDBusy = 1'b0;
    MDDone = 1'b0;
    case (state)
      RUN:     MDBusy = 1'b1;
      DONE:    MDDone = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q     <= OP_MUL;
      res_neg  <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MDStart) begin
            op_q    <= op_in;
            res_neg <= start_neg;
            cnt     <= '0;
            hi      <= '0;
            lo      <= a_mag;
            opb     <= b_mag;
            if (special)
              result_q <= special_val;
            else if (fast_hit)
              result_q <= fast_val;
          end
        end
        RUN: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + 1'b1;
          if (last)
            result_q <= run_val;
        end
        default: ;
      endcase
    end
  end

  assign MDResult = result_q;

endmodule
